// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm-clock keypad and time-set paths.
package alarm_clock_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned MAX_HOUR     = 23;
  localparam int unsigned MAX_MIN_TENS = 5;
  localparam int unsigned MAX_DIGIT    = 9;
  localparam int unsigned ENTRY_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } entry_state_e;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] value);
    return value <= DIGIT_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational legal 24-hour HH:MM check over four BCD digits.
module bcd_time_check
  import alarm_clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_ms_hr,
  input  logic [DIGIT_W-1:0] i_ls_hr,
  input  logic [DIGIT_W-1:0] i_ms_min,
  input  logic [DIGIT_W-1:0] i_ls_min,
  output logic               o_legal
);

  logic [4:0] w_hours;

  assign w_hours = (5'(i_ms_hr) * 5'd10) + 5'(i_ls_hr);

  // Tens-of-hours bound keeps the 5-bit hour sum from wrapping.
  assign o_legal = (i_ms_hr <= DIGIT_W'(2))
                && (w_hours <= 5'(MAX_HOUR))
                && (i_ms_min <= DIGIT_W'(MAX_MIN_TENS))
                && (i_ls_min <= DIGIT_W'(MAX_DIGIT));

endmodule

// File: rtl/key_entry_buf.sv
// Keypad digit-entry buffer feeding the alarm register's new_alarm inputs.
// Optional idle-timeout discard is built when KEY_ENTRY_TIMEOUT_EN is defined.
module key_entry_buf
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_value,
  input  logic               clear_entry,
  input  logic               load_new_alarm,
  output logic [DIGIT_W-1:0] key_buffer_ms_hr,
  output logic [DIGIT_W-1:0] key_buffer_ls_hr,
  output logic [DIGIT_W-1:0] key_buffer_ms_min,
  output logic [DIGIT_W-1:0] key_buffer_ls_min,
  output logic [2:0]         digit_count,
  output logic               entry_valid,
  output logic               entry_timeout
);

  entry_state_e       r_state, w_state_nxt;
  logic [DIGIT_W-1:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic [DIGIT_W-1:0] w_ms_hr_nxt, w_ls_hr_nxt, w_ms_min_nxt, w_ls_min_nxt;
  logic [2:0]         r_count, w_count_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_accept;
  logic               w_timeout_hit;
  logic               w_legal;

  assign w_accept = key_valid && is_digit(key_value);

`ifdef KEY_ENTRY_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] r_idle_cnt, w_idle_cnt_nxt;

  assign w_timeout_hit = (r_state != IDLE) && (r_idle_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_idle_cnt_nxt = r_idle_cnt + CntW'(1);
    // Any discard lands in IDLE; a surviving accepted digit restarts the wait.
    if (w_state_nxt == IDLE || w_accept) begin
      w_idle_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_timeout_hit        = 1'b0;
  assign w_unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_ms_hr_nxt   = r_ms_hr;
    w_ls_hr_nxt   = r_ls_hr;
    w_ms_min_nxt  = r_ms_min;
    w_ls_min_nxt  = r_ls_min;
    w_count_nxt   = r_count;
    w_timeout_nxt = 1'b0;

    if (clear_entry || load_new_alarm || w_timeout_hit) begin
      w_state_nxt   = IDLE;
      w_ms_hr_nxt   = '0;
      w_ls_hr_nxt   = '0;
      w_ms_min_nxt  = '0;
      w_ls_min_nxt  = '0;
      w_count_nxt   = '0;
      w_timeout_nxt = w_timeout_hit && !clear_entry && !load_new_alarm;
    end else if (w_accept) begin
      w_ms_hr_nxt  = r_ls_hr;
      w_ls_hr_nxt  = r_ms_min;
      w_ms_min_nxt = r_ls_min;
      w_ls_min_nxt = key_value;
      unique case (r_state)
        IDLE: begin
          w_state_nxt = ENTRY;
          w_count_nxt = 3'd1;
        end
        ENTRY: begin
          w_count_nxt = r_count + 3'd1;
          if (r_count == 3'(ENTRY_DIGITS - 1)) begin
            w_state_nxt = FULL;
          end
        end
        FULL: begin
          w_count_nxt = 3'(ENTRY_DIGITS);
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  bcd_time_check u_time_check (
    .i_ms_hr  (w_ms_hr_nxt),
    .i_ls_hr  (w_ls_hr_nxt),
    .i_ms_min (w_ms_min_nxt),
    .i_ls_min (w_ls_min_nxt),
    .o_legal  (w_legal)
  );

  assign w_valid_nxt = (w_count_nxt == 3'(ENTRY_DIGITS)) && w_legal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ms_hr   <= '0;
      r_ls_hr   <= '0;
      r_ms_min  <= '0;
      r_ls_min  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ms_hr   <= w_ms_hr_nxt;
      r_ls_hr   <= w_ls_hr_nxt;
      r_ms_min  <= w_ms_min_nxt;
      r_ls_min  <= w_ls_min_nxt;
      r_count   <= w_count_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign key_buffer_ms_hr  = r_ms_hr;
  assign key_buffer_ls_hr  = r_ls_hr;
  assign key_buffer_ms_min = r_ms_min;
  assign key_buffer_ls_min = r_ls_min;
  assign digit_count       = r_count;
  assign entry_valid       = r_valid;
  assign entry_timeout     = r_timeout;

endmodule

// File: tb/tb_key_entry_buf.sv
// Self-checking bench for key_entry_buf: directed test-plan steps plus random keys vs a model.
module tb_key_entry_buf;

  localparam int TimeoutCycles = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       clear_entry = 1'b0;
  logic       load_new_alarm = 1'b0;
  logic [3:0] key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min;
  logic [2:0] digit_count;
  logic       entry_valid;
  logic       entry_timeout;

  int tests = 0;
  int fails = 0;

  // Reference model: digits accepted since the last discard, and edges since the last digit.
  int hist[$];
  int since_digit = 0;
  int exp_timeout = 0;
  int timeout_pulses = 0;

  always #5 clock = ~clock;

  key_entry_buf #(
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .key_valid         (key_valid),
    .key_value         (key_value),
    .clear_entry       (clear_entry),
    .load_new_alarm    (load_new_alarm),
    .key_buffer_ms_hr  (key_buffer_ms_hr),
    .key_buffer_ls_hr  (key_buffer_ls_hr),
    .key_buffer_ms_min (key_buffer_ms_min),
    .key_buffer_ls_min (key_buffer_ls_min),
    .digit_count       (digit_count),
    .entry_valid       (entry_valid),
    .entry_timeout     (entry_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window digit k (0 = ms_hr): newest digits right-aligned, zero padding on the left.
  function automatic int exp_digit(input int k);
    int pad;
    pad = 4 - hist.size();
    return (k >= pad) ? hist[k - pad] : 0;
  endfunction

  function automatic int exp_valid();
    if (hist.size() != 4) return 0;
    return ((hist[0] * 10 + hist[1]) <= 23 && hist[2] <= 5 && hist[3] <= 9) ? 1 : 0;
  endfunction

  task automatic model_edge(input logic c, input logic l, input logic kv, input logic [3:0] kval);
    int to_hit;
    to_hit = 0;
`ifdef KEY_ENTRY_TIMEOUT_EN
    if (hist.size() > 0 && since_digit + 1 == TimeoutCycles) to_hit = 1;
`endif
    exp_timeout = 0;
    if (c || l || to_hit != 0) begin
      hist.delete();
      since_digit = 0;
      exp_timeout = (to_hit != 0 && !c && !l) ? 1 : 0;
    end else if (kv && kval <= 4'd9) begin
      hist.push_back(int'(kval));
      if (hist.size() > 4) void'(hist.pop_front());
      since_digit = 0;
    end else if (hist.size() > 0) begin
      since_digit++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ms_hr"},  32'(key_buffer_ms_hr),  32'(exp_digit(0)));
    check({tag, ".ls_hr"},  32'(key_buffer_ls_hr),  32'(exp_digit(1)));
    check({tag, ".ms_min"}, 32'(key_buffer_ms_min), 32'(exp_digit(2)));
    check({tag, ".ls_min"}, 32'(key_buffer_ls_min), 32'(exp_digit(3)));
    check({tag, ".count"},  32'(digit_count),       32'(hist.size()));
    check({tag, ".valid"},  32'(entry_valid),       32'(exp_valid()));
    check({tag, ".timeout"}, 32'(entry_timeout),    32'(exp_timeout));
  endtask

  task automatic step(input string tag, input logic c, input logic l, input logic kv,
                      input logic [3:0] kval);
    clear_entry    = c;
    load_new_alarm = l;
    key_valid      = kv;
    key_value      = kval;
    @(posedge clock);
    #1;
    model_edge(c, l, kv, kval);
    if (entry_timeout === 1'b1) timeout_pulses++;
    check_all(tag);
    clear_entry    = 1'b0;
    load_new_alarm = 1'b0;
    key_valid      = 1'b0;
    key_value      = 4'd0;
  endtask

  task automatic key(input string tag, input logic [3:0] kval);
    step(tag, 1'b0, 1'b0, 1'b1, kval);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;
    idle("post_reset", 1);

    // Reset asserted mid-entry
    key("rst_k1", 4'd1);
    key("rst_k2", 4'd2);
    #2;
    reset = 1'b0;
    #1;
    hist.delete();
    since_digit = 0;
    exp_timeout = 0;
    check_all("reset_mid");
    @(negedge clock);
    reset = 1'b1;

    // Legal entry 12:30
    key("k1230a", 4'd1);
    key("k1230b", 4'd2);
    key("k1230c", 4'd3);
    key("k1230d", 4'd0);
    check("valid_1230", 32'(entry_valid), 32'd1);
    step("clr_a", 1'b1, 1'b0, 1'b0, 4'd0);

    // Hour 25 is illegal; sliding window; non-digit key ignored
    key("k2500a", 4'd2);
    key("k2500b", 4'd5);
    key("k2500c", 4'd0);
    key("k2500d", 4'd0);
    key("slide9", 4'd9);
    key("nondigit", 4'd10);
    check("window_5009", 32'({key_buffer_ms_hr, key_buffer_ls_hr,
                              key_buffer_ms_min, key_buffer_ls_min}), 32'h5009);
    step("clr_b", 1'b1, 1'b0, 1'b0, 4'd0);

    // 07:45 hand-off, then load with a coincident key
    key("k0745a", 4'd0);
    key("k0745b", 4'd7);
    key("k0745c", 4'd4);
    key("k0745d", 4'd5);
    check("pre_load_0745", 32'({key_buffer_ms_hr, key_buffer_ls_hr,
                                key_buffer_ms_min, key_buffer_ls_min}), 32'h0745);
    step("load", 1'b0, 1'b1, 1'b0, 4'd0);
    key("k8", 4'd8);
    step("load_key", 1'b0, 1'b1, 1'b1, 4'd6);

    // Clear with a coincident key
    key("k4", 4'd4);
    step("clr_key", 1'b1, 1'b0, 1'b1, 4'd3);

`ifdef KEY_ENTRY_TIMEOUT_EN
    timeout_pulses = 0;
    key("to_k3", 4'd3);
    idle("to_idle", TimeoutCycles);
    check("to_pulses", 32'(timeout_pulses), 32'd1);
    check("to_count", 32'(digit_count), 32'd0);
    idle("to_after", 2);

    timeout_pulses = 0;
    key("nt_k3", 4'd3);
    for (int i = 0; i < 6; i++) begin
      idle("nt_idle", 4);
      key("nt_key", 4'(i));
    end
    check("nt_pulses", 32'(timeout_pulses), 32'd0);
    step("clr_c", 1'b1, 1'b0, 1'b0, 4'd0);
`else
    key("persist_k", 4'd2);
    idle("persist_idle", 20);
    check("persist_count", 32'(digit_count), 32'd1);
    step("clr_c", 1'b1, 1'b0, 1'b0, 4'd0);
`endif

    // Randomized keys, with occasional clears, loads and idle gaps
    for (int i = 0; i < 400; i++) begin
      int r;
      logic c, l, kv;
      r  = int'($urandom_range(0, 99));
      c  = (r < 3);
      l  = (r >= 3 && r < 6);
      kv = ($urandom_range(0, 99) < 45);
      step("rand", c, l, kv, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) idle("rand_gap", int'($urandom_range(5, 12)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_entry_buf.md
# key_entry_buf

Keypad digit-entry buffer sitting directly upstream of the alarm register. It accepts decoded key presses one BCD digit at a time and shifts them into a four-digit HH:MM window. It presents the window on `key_buffer_*` outputs that drive the alarm register's `new_alarm_*` inputs, and flags when the window holds a legal 24-hour time. The buffer clears itself when the controller pulses `load_new_alarm`, so the alarm register captures the value on that same edge.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle clock cycles before a partial or complete entry is discarded. Used only with `KEY_ENTRY_TIMEOUT_EN`.
- `clock`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_value` is meaningful.
- `key_value`  in  4  decoded key code. 0-9 are digits; 10-15 are non-digit keys.
- `clear_entry`  in  1  discard the current entry.
- `load_new_alarm`  in  1  controller strobe shared with the alarm register; buffer contents are consumed this edge.
- `key_buffer_ms_hr`, `key_buffer_ls_hr`, `key_buffer_ms_min`, `key_buffer_ls_min`  out  4 each  buffered digits, oldest in `ms_hr`.
- `digit_count`  out  3  accepted digits in the buffer, 0-4.
- `entry_valid`  out  1  buffer is full and forms a legal time.
- `entry_timeout`  out  1  one-cycle pulse when a timeout discard occurs.

## Operation
- **States:**
  - IDLE: count 0.
  - ENTRY: count 1-3.
  - FULL: count 4.
- **Accepted digit:** `key_valid`=1 and `key_value`≤9. Digits shift left: `ms_hr`←`ls_hr`←`ms_min`←`ls_min`←`key_value`.
- **Digit count:** increments by one per accepted digit and saturates at 4.
  - IDLE→ENTRY on the first digit.
  - ENTRY→FULL on the fourth digit.
  - In FULL, further digits keep shifting as a sliding window; count stays 4 and state stays FULL.
- **Non-digit keys:** `key_value`≥10 is ignored entirely. No shift, no count change, no timeout restart.
- **Discard:** `clear_entry` or `load_new_alarm` clears all digits to 0, clears count to 0, and returns to IDLE.
- **Per-edge priority**, highest first:
  1. `clear_entry`
  2. `load_new_alarm`
  3. timeout
  4. accepted digit
  A digit arriving on the same edge as any higher-priority event is dropped.
- **`entry_valid` rule:** high iff count is 4, hours (`ms_hr`·10+`ls_hr`) ≤ 23, `ms_min` ≤ 5 and `ls_min` ≤ 9.
- **Arithmetic:** hour comparison uses a 5-bit sum; no BCD carries are performed.

## Timing
- **Reset values:** all `key_buffer_*` = 0, `digit_count` = 0, `entry_valid` = 0, `entry_timeout` = 0, state IDLE. Reset mid-entry discards everything immediately.
- **Latency:** all outputs are registered. A digit sampled at edge N is visible, with the updated `digit_count` and `entry_valid`, after edge N. `entry_valid` is computed from next-state values, so there is no extra cycle.
- **Hand-off:** the alarm register and this block sample `load_new_alarm` on the same edge. The alarm register captures the pre-clear contents; this block shows zeros afterwards.
- **Back-to-back keys:** `key_valid` on consecutive cycles is legal. Every cycle's digit is accepted.

## Configuration
- **With `KEY_ENTRY_TIMEOUT_EN` defined:**
  - An idle counter, width clog2(`TIMEOUT_CYCLES`), runs in ENTRY and FULL and is held at 0 in IDLE.
  - The counter reloads to 0 on every accepted digit.
  - When it reaches `TIMEOUT_CYCLES`-1 the buffer is discarded as for `clear_entry`, and `entry_timeout` pulses high for one cycle.
- **Without the macro:** no counter is built. `entry_timeout` is tied 0 and entries persist indefinitely.

## Structure
- **Package `alarm_clock_pkg`:**
  - `DIGIT_W`=4
  - `MAX_HOUR`=23
  - `MAX_MIN_TENS`=5
  - the entry-state enum (IDLE, ENTRY, FULL)
- **Sub-module `bcd_time_check`:** combinational legal-time check over four digits. It is reused by the time-set path.

## Test plan
- Reset low mid-entry after keys 1,2 → all outputs 0, state IDLE.
- Keys 1,2,3,0 → after the fourth edge the digits read 1,2,3,0; `digit_count`=4; `entry_valid`=1.
- Keys 2,5,0,0 → `digit_count`=4, `entry_valid`=0 (hour 25). A further key 9 → window 5,0,0,9, `entry_valid`=0. Key 10 → no change.
- Keys 0,7,4,5 then `load_new_alarm` → the alarm register captures 07:45; this block reads 0 with count 0 the next cycle. `load_new_alarm` together with a key → the key is dropped.
- `clear_entry` with `key_valid`=1 on the same edge → buffer 0, count 0.
- `KEY_ENTRY_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8:
  - Key 3, then 8 idle cycles → `entry_timeout` pulses once and `digit_count` goes to 0.
  - Key 3, then a key every 5 cycles → no timeout.
